dspl_msg_fmt: RTL and testbench

DSPL_MSG_FMT -- requirements
Module: dspl_msg_fmt

---
 rtl/dspl_pkg.sv | 38 +++
 rtl/ms_tick_gen.sv | 19 +
 rtl/dspl_msg_fmt.sv | 131 +++++++++++++
 tb/tb_dspl_msg_fmt.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/dspl_pkg.sv
// dspl_pkg: display codes, phase encoding, FSM states and digit-word layout
package dspl_pkg;
    localparam logic [3:0] C_J     = 4'h5;
    localparam logic [3:0] C_S     = 4'h6;
    localparam logic [3:0] C_E     = 4'h7;
    localparam logic [3:0] C_T     = 4'h8;
    localparam logic [3:0] C_U     = 4'h9;
    localparam logic [3:0] C_P     = 4'hA;
    localparam logic [3:0] C_B     = 4'hB;
    localparam logic [3:0] C_C     = 4'hC;
    localparam logic [3:0] C_L     = 4'hD;
    localparam logic [3:0] C_Y     = 4'hE;
    localparam logic [3:0] C_BLANK = 4'hF;

    localparam logic [1:0] PH_IDLE  = 2'b00;
    localparam logic [1:0] PH_SETUP = 2'b01;
    localparam logic [1:0] PH_GUESS = 2'b10;
    localparam logic [1:0] PH_WIN   = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_GUESS, S_RESULT, S_WIN} state_t;

    typedef struct packed {
        logic       en;
        logic [3:0] code;
        logic       dp_n;
    } dword_t;

    localparam dword_t W_OFF = '{en: 1'b0, code: C_BLANK, dp_n: 1'b1};

    // Only numerals 0-4 have glyphs; anything larger is shown blank.
    function automatic logic [3:0] num_code(input logic [2:0] v);
        return (v > 3'd4) ? C_BLANK : {1'b0, v};
    endfunction

    function automatic dword_t word(input logic [3:0] c);
        return '{en: 1'b1, code: c, dp_n: 1'b1};
    endfunction
endpackage

// File: rtl/ms_tick_gen.sv
// ms_tick_gen: one-cycle pulse every MS_COUNT clock cycles
module ms_tick_gen #(
    parameter int MS_COUNT = 100000
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);
    localparam int W = (MS_COUNT > 1) ? $clog2(MS_COUNT) : 1;

    logic [W-1:0] cnt;

    assign tick = (cnt == W'(MS_COUNT - 1));

    always_ff @(posedge clock) begin
        if (!reset) cnt <= '0;
        else        cnt <= tick ? '0 : cnt + W'(1);
    end
endmodule

// File: rtl/dspl_msg_fmt.sv
// dspl_msg_fmt: formats game phase, entry and results into eight 7-seg digit words
module dspl_msg_fmt
    import dspl_pkg::*;
#(
    parameter int MS_COUNT = 100000,
    parameter int HOLD_MS  = 2000,
    parameter int BLINK_MS = 250
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  phase,
    input  logic        player,
    input  logic [11:0] entry,
    input  logic [2:0]  entry_cnt,
    input  logic        res_valid,
    output logic        res_ready,
    input  logic [2:0]  bulls,
    input  logic [2:0]  cows,
    output logic [5:0]  d1,
    output logic [5:0]  d2,
    output logic [5:0]  d3,
    output logic [5:0]  d4,
    output logic [5:0]  d5,
    output logic [5:0]  d6,
    output logic [5:0]  d7,
    output logic [5:0]  d8
);
    localparam int HW = $clog2(HOLD_MS + 1);
    localparam int BW = $clog2(BLINK_MS + 1);

    state_t        state, nxt, ph_state;
    logic          tick, hs, hold_done, blink_wrap, blink, nxt_blink;
    logic [HW-1:0] hold_cnt;
    logic [BW-1:0] blink_cnt;
    logic [2:0]    cap_b, cap_c, nxt_b, nxt_c;
    logic [3:0]    pcode;
    dword_t        dw [8];
    dword_t        nw [8];

    ms_tick_gen #(.MS_COUNT(MS_COUNT)) u_tick (.clock(clock), .reset(reset), .tick(tick));

    assign ph_state   = (phase == PH_SETUP) ? S_SETUP :
                        (phase == PH_GUESS) ? S_GUESS :
                        (phase == PH_WIN)   ? S_WIN   : S_IDLE;
    assign res_ready  = (state == S_SETUP) || (state == S_GUESS);
    assign hs         = res_valid && res_ready;
    assign hold_done  = tick && (hold_cnt == HW'(HOLD_MS - 1));
    assign blink_wrap = tick && (blink_cnt == BW'(BLINK_MS - 1));
    assign nxt_b      = hs ? bulls : cap_b;
    assign nxt_c      = hs ? cows : cap_c;
    assign pcode      = {3'b000, player} + 4'd1;

    always_comb begin
        nxt = ph_state;
        if (state == S_RESULT)
            nxt = (phase == PH_IDLE || phase == PH_WIN || hold_done) ? ph_state : S_RESULT;
        else if (hs)
            nxt = S_RESULT;
    end

    // Blink restarts in its lit half on every state entry.
    assign nxt_blink = (nxt != state) ? 1'b0 : blink ^ blink_wrap;

    // Words are built from next-cycle values so they change with the state register.
    always_comb begin
        nw = '{default: W_OFF};
        case (nxt)
            S_SETUP, S_GUESS: begin
                nw[7] = word((nxt == S_SETUP) ? C_S : C_J);
                nw[6] = word((nxt == S_SETUP) ? C_E : pcode);
                nw[5] = word((nxt == S_SETUP) ? C_T : C_BLANK);
                nw[4] = word(C_BLANK);
                for (int i = 0; i < 4; i++)
                    nw[3-i] = '{en:   1'b1,
                                code: (3'(i) < entry_cnt) ? num_code(entry[11-3*i -: 3]) : C_BLANK,
                                dp_n: (entry_cnt < 3'd4 && entry_cnt == 3'(i)) ? nxt_blink : 1'b1};
            end
            S_RESULT: begin
                nw[7] = word(C_B);
                nw[6] = word(num_code(nxt_b));
                nw[5] = word(C_BLANK);
                nw[4] = word(C_BLANK);
                nw[3] = word(C_C);
                nw[2] = word(num_code(nxt_c));
                nw[1] = word(C_BLANK);
                nw[0] = word(C_BLANK);
            end
            S_WIN: begin
                nw[7] = word(C_J);
                nw[6] = word(pcode);
                nw[5] = word(C_BLANK);
                nw[4] = word(C_B);
                nw[3] = word(C_U);
                nw[2] = word(C_L);
                nw[1] = word(C_L);
                nw[0] = word(C_S);
                for (int i = 0; i < 8; i++) nw[i].en = ~nxt_blink;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= S_IDLE;
            blink     <= 1'b0;
            blink_cnt <= '0;
            hold_cnt  <= '0;
            cap_b     <= '0;
            cap_c     <= '0;
            dw        <= '{default: W_OFF};
        end else begin
            state     <= nxt;
            blink     <= nxt_blink;
            cap_b     <= nxt_b;
            cap_c     <= nxt_c;
            dw        <= nw;
            blink_cnt <= (nxt != state || blink_wrap) ? '0 : blink_cnt + BW'(tick);
            hold_cnt  <= (nxt != state) ? '0 : hold_cnt + HW'(tick && state == S_RESULT);
        end
    end

    assign d1 = dw[0];
    assign d2 = dw[1];
    assign d3 = dw[2];
    assign d4 = dw[3];
    assign d5 = dw[4];
    assign d6 = dw[5];
    assign d7 = dw[6];
    assign d8 = dw[7];
endmodule

// File: tb/tb_dspl_msg_fmt.sv
// tb_dspl_msg_fmt: random stimulus against a behavioural display model, plus literal spot checks
module tb_dspl_msg_fmt;
    localparam int MS    = 4;
    localparam int HOLD  = 6;
    localparam int BLINK = 3;
    localparam int M_IDLE = 0, M_SETUP = 1, M_GUESS = 2, M_RESULT = 3, M_WIN = 4;

    logic        clock, reset, player, res_valid, res_ready;
    logic [1:0]  phase;
    logic [11:0] entry;
    logic [2:0]  entry_cnt, bulls, cows;
    logic [5:0]  d1, d2, d3, d4, d5, d6, d7, d8;
    logic [5:0]  dd [1:8];

    int checks = 0;
    int errors = 0;

    int   mode, tin, cyc, cb, cc, blink;
    bit   mvalid = 0;
    logic exp_ready;
    logic [5:0] exp_d [1:8];

    dspl_msg_fmt #(.MS_COUNT(MS), .HOLD_MS(HOLD), .BLINK_MS(BLINK)) dut (
        .clock(clock), .reset(reset), .phase(phase), .player(player), .entry(entry),
        .entry_cnt(entry_cnt), .res_valid(res_valid), .res_ready(res_ready),
        .bulls(bulls), .cows(cows),
        .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6), .d7(d7), .d8(d8)
    );

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    always_comb begin
        dd[1] = d1; dd[2] = d2; dd[3] = d3; dd[4] = d4;
        dd[5] = d5; dd[6] = d6; dd[7] = d7; dd[8] = d8;
    end

    task automatic chk(input string nm, input logic [5:0] got, input logic [5:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", nm, got, want, $time);
        end
    endtask

    function automatic logic [3:0] num(input int v);
        return (v > 4) ? 4'hF : 4'(v);
    endfunction

    function automatic logic [5:0] w(input logic en, input logic [3:0] c, input logic dp);
        return {en, c, dp};
    endfunction

    task automatic model_step();
        int want, nm, tk, v;
        logic [3:0] pc;
        if (!reset) begin
            mvalid = 1; mode = M_IDLE; tin = 0; cyc = 0; cb = 0; cc = 0;
        end else begin
            tk = ((cyc % MS) == MS - 1) ? 1 : 0;
            cyc++;
            want = (phase == 2'b01) ? M_SETUP : (phase == 2'b10) ? M_GUESS :
                   (phase == 2'b11) ? M_WIN : M_IDLE;
            if (mode == M_RESULT)
                nm = (phase == 2'b00 || phase == 2'b11 || tin + tk >= HOLD) ? want : M_RESULT;
            else if (res_valid && (mode == M_SETUP || mode == M_GUESS)) begin
                nm = M_RESULT; cb = int'(bulls); cc = int'(cows);
            end else
                nm = want;
            tin = (nm != mode) ? 0 : tin + tk;
            mode = nm;
        end
        blink = (tin / BLINK) % 2;
        exp_ready = (mode == M_SETUP || mode == M_GUESS);
        pc = player ? 4'd2 : 4'd1;
        for (int k = 1; k <= 8; k++) exp_d[k] = 6'h1F;
        if (mode == M_SETUP || mode == M_GUESS) begin
            exp_d[8] = w(1, (mode == M_SETUP) ? 4'h6 : 4'h5, 1);
            exp_d[7] = w(1, (mode == M_SETUP) ? 4'h7 : pc, 1);
            exp_d[6] = w(1, (mode == M_SETUP) ? 4'h8 : 4'hF, 1);
            exp_d[5] = w(1, 4'hF, 1);
            for (int i = 0; i < 4; i++) begin
                v = int'((entry >> (9 - 3 * i)) & 12'h7);
                exp_d[4-i] = w(1, (i < int'(entry_cnt)) ? num(v) : 4'hF,
                               (entry_cnt < 4 && i == int'(entry_cnt)) ? 1'(blink) : 1'b1);
            end
        end else if (mode == M_RESULT) begin
            for (int k = 1; k <= 8; k++) exp_d[k] = w(1, 4'hF, 1);
            exp_d[8] = w(1, 4'hB, 1);
            exp_d[7] = w(1, num(cb), 1);
            exp_d[4] = w(1, 4'hC, 1);
            exp_d[3] = w(1, num(cc), 1);
        end else if (mode == M_WIN) begin
            exp_d[8] = w(!blink, 4'h5, 1);
            exp_d[7] = w(!blink, pc, 1);
            exp_d[6] = w(!blink, 4'hF, 1);
            exp_d[5] = w(!blink, 4'hB, 1);
            exp_d[4] = w(!blink, 4'h9, 1);
            exp_d[3] = w(!blink, 4'hD, 1);
            exp_d[2] = w(!blink, 4'hD, 1);
            exp_d[1] = w(!blink, 4'h6, 1);
        end
    endtask

    initial begin
        forever begin
            @(posedge clock);
            model_step();
            #1;
            if (mvalid) begin
                for (int k = 1; k <= 8; k++) chk($sformatf("model_d%0d", k), dd[k], exp_d[k]);
                chk("model_res_ready", {5'b0, res_ready}, {5'b0, exp_ready});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic chk8(input string nm, input logic [5:0] a8, input logic [5:0] a7,
                        input logic [5:0] a6, input logic [5:0] a5, input logic [5:0] a4,
                        input logic [5:0] a3, input logic [5:0] a2, input logic [5:0] a1);
        chk({nm, "_d8"}, d8, a8); chk({nm, "_d7"}, d7, a7);
        chk({nm, "_d6"}, d6, a6); chk({nm, "_d5"}, d5, a5);
        chk({nm, "_d4"}, d4, a4); chk({nm, "_d3"}, d3, a3);
        chk({nm, "_d2"}, d2, a2); chk({nm, "_d1"}, d1, a1);
    endtask

    initial begin
        bit found;
        reset = 0; phase = 2'b00; player = 0; entry = '0; entry_cnt = 0;
        res_valid = 0; bulls = 0; cows = 0;
        step(3);
        reset = 1;
        step(2);
        chk8("reset", 6'h1F, 6'h1F, 6'h1F, 6'h1F, 6'h1F, 6'h1F, 6'h1F, 6'h1F);
        chk("reset_ready", {5'b0, res_ready}, 6'h00);

        phase = 2'b01; entry_cnt = 3'd2; entry = {3'd3, 3'd1, 3'd6, 3'd5};
        step(1);
        chk8("setup", 6'h2D, 6'h2F, 6'h31, 6'h3F, 6'h27, 6'h23, 6'h3E, 6'h3F);
        step(12);
        chk("setup_cursor_off", d2, 6'h3F);

        phase = 2'b10;
        step(3);
        res_valid = 1; bulls = 3'd2; cows = 3'd1;
        step(1);
        res_valid = 0;
        chk8("result", 6'h37, 6'h25, 6'h3F, 6'h3F, 6'h39, 6'h23, 6'h3F, 6'h3F);
        chk("result_ready", {5'b0, res_ready}, 6'h00);
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            step(1);
            if (d8 == 6'h2B) found = 1;
        end
        chk("hold_return", {5'b0, found}, 6'h01);
        chk("hold_return_d7", d7, 6'h23);

        res_valid = 1; bulls = 3'd5; cows = 3'd4;
        step(1);
        res_valid = 0;
        chk("bulls5_blank", d7, 6'h3F);
        chk("cows4", d3, 6'h29);
        step(2);
        phase = 2'b11; res_valid = 1;
        step(1);
        chk8("win", 6'h2B, 6'h23, 6'h3F, 6'h37, 6'h33, 6'h3B, 6'h3B, 6'h2D);
        for (int i = 0; i < 12; i++) begin
            step(1);
            chk("win_ready", {5'b0, res_ready}, 6'h00);
        end
        chk("win_blink_d8", d8, 6'h0B);
        res_valid = 0;

        phase = 2'b01; entry_cnt = 3'd4; entry = {3'd7, 3'd4, 3'd0, 3'd2};
        step(1);
        chk8("entry7", 6'h2D, 6'h2F, 6'h31, 6'h3F, 6'h3F, 6'h29, 6'h21, 6'h25);

        phase = 2'b10;
        step(3);
        res_valid = 1; bulls = 3'd3; cows = 3'd0;
        step(1);
        res_valid = 0;
        step(2);
        reset = 0;
        step(1);
        chk8("mid_reset", 6'h1F, 6'h1F, 6'h1F, 6'h1F, 6'h1F, 6'h1F, 6'h1F, 6'h1F);
        chk("mid_reset_ready", {5'b0, res_ready}, 6'h00);
        reset = 1;
        step(1);
        chk("post_reset_d8", d8, 6'h2B);
        chk("post_reset_d7", d7, 6'h23);

        for (int n = 0; n < 3000; n++) begin
            @(negedge clock);
            reset = ($urandom_range(0, 399) != 0);
            if ($urandom_range(0, 29) == 0) phase = 2'($urandom_range(0, 3));
            player    = 1'($urandom);
            entry     = 12'($urandom);
            entry_cnt = 3'($urandom_range(0, 4));
            res_valid = ($urandom_range(0, 7) == 0);
            bulls     = 3'($urandom);
            cows      = 3'($urandom);
        end
        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
